// File: rtl/led_flow_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : led_flow_ctrl
//  Description : Four-LED pattern controller. Two command requesters
//                (A = keys, high priority; B = host, low priority) share a
//                single pending-command slot. Accepted commands select the
//                pattern (stop, flow left, flow right, blink), pause and
//                resume it, or change the step speed. A base counter plus a
//                speed-scaled step counter produce the pattern step pulse.
//  Ports       :
//    sys_clk      in   1  system clock
//    sys_rst      in   1  asynchronous reset, active-high
//    req_a_valid  in   1  key command valid
//    req_a_cmd    in   3  key command code
//    req_a_ready  out  1  key command accepted when valid & ready
//    req_b_valid  in   1  host command valid
//    req_b_cmd    in   3  host command code
//    req_b_ready  out  1  host command accepted when valid & ready
//    led          out  4  registered LED drive
//    mode         out  3  STOP=0, FLOW_L=1, FLOW_R=2, BLINK=3, PAUSED=4
//    speed        out  2  speed index, 0 fastest .. 3 slowest
//    tick         out  1  one-cycle pulse on each pattern step
//  Revision    : 1.0  initial release
// ============================================================================
module led_flow_ctrl #(
  parameter logic [23:0] TICK_BASE = 24'd5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req_a_valid,
  input  logic [2:0] req_a_cmd,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [2:0] req_b_cmd,
  output logic       req_b_ready,
  output logic [3:0] led,
  output logic [2:0] mode,
  output logic [1:0] speed,
  output logic       tick
);

  localparam logic [2:0] ST_STOP   = 3'd0;
  localparam logic [2:0] ST_FLOW_L = 3'd1;
  localparam logic [2:0] ST_FLOW_R = 3'd2;
  localparam logic [2:0] ST_BLINK  = 3'd3;
  localparam logic [2:0] ST_PAUSED = 3'd4;

  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_FLOW_L = 3'd1;
  localparam logic [2:0] CMD_FLOW_R = 3'd2;
  localparam logic [2:0] CMD_BLINK  = 3'd3;
  localparam logic [2:0] CMD_PAUSE  = 3'd4;
  localparam logic [2:0] CMD_SPD_UP = 3'd5;
  localparam logic [2:0] CMD_SPD_DN = 3'd6;
  localparam logic [2:0] CMD_RSVD   = 3'd7;

  localparam logic [23:0] BASE_LAST = TICK_BASE - 24'd1;

  logic [2:0]  mode_q,  mode_d;
  logic [2:0]  saved_q, saved_d;
  logic [3:0]  led_q,   led_d;
  logic [1:0]  speed_q, speed_d;
  logic        pend_q,  pend_d;
  logic [2:0]  cmd_q,   cmd_d;
  logic [23:0] base_q,  base_d;
  logic [1:0]  step_q,  step_d;

  logic       w_rdy_a;
  logic       w_rdy_b;
  logic       w_acc_a;
  logic       w_acc_b;
  logic       w_accept;
  logic [2:0] w_acc_cmd;
  logic       w_apply;
  logic       w_running;
  logic       w_at_end;
  logic       w_tick;
  logic       w_onehot;

  // Readies are forced low while reset is held, independent of the clock.
  assign w_rdy_a   = ~pend_q & ~sys_rst;
  assign w_rdy_b   = w_rdy_a & ~req_a_valid;
  assign w_acc_a   = req_a_valid & w_rdy_a;
  assign w_acc_b   = req_b_valid & w_rdy_b;
  assign w_accept  = w_acc_a | w_acc_b;
  assign w_acc_cmd = w_acc_a ? req_a_cmd : req_b_cmd;

  // The reserved code is consumed by the pend slot but must not disturb
  // the counters or swallow a tick.
  assign w_apply   = pend_q & (cmd_q != CMD_RSVD);

  assign w_running = (mode_q == ST_FLOW_L) | (mode_q == ST_FLOW_R) |
                     (mode_q == ST_BLINK);
  assign w_at_end  = (base_q == BASE_LAST) & (step_q == speed_q);
  // A command landing on the same edge takes precedence over the step.
  assign w_tick    = w_running & w_at_end & ~w_apply;

  assign w_onehot  = (led_q == 4'b0001) | (led_q == 4'b0010) |
                     (led_q == 4'b0100) | (led_q == 4'b1000);

  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    led_d   = led_q;
    speed_d = speed_q;
    pend_d  = w_accept;
    cmd_d   = w_accept ? w_acc_cmd : cmd_q;
    base_d  = base_q;
    step_d  = step_q;

    // Step timing: base wraps every TICK_BASE cycles, step counts base
    // wraps up to the speed index, giving TICK_BASE*(speed+1) per step.
    if (!w_running || w_apply) begin
      base_d = 24'd0;
      step_d = 2'd0;
    end else if (base_q == BASE_LAST) begin
      base_d = 24'd0;
      step_d = (step_q == speed_q) ? 2'd0 : step_q + 2'd1;
    end else begin
      base_d = base_q + 24'd1;
    end

    if (w_apply) begin
      case (cmd_q)
        CMD_STOP: begin
          mode_d = ST_STOP;
          led_d  = 4'b0000;
        end
        CMD_FLOW_L: begin
          mode_d = ST_FLOW_L;
          // Switching direction or resuming keeps a valid running dot.
          if (!(w_onehot && (mode_q == ST_FLOW_R || mode_q == ST_PAUSED))) begin
            led_d = 4'b0001;
          end
        end
        CMD_FLOW_R: begin
          mode_d = ST_FLOW_R;
          if (!(w_onehot && (mode_q == ST_FLOW_L || mode_q == ST_PAUSED))) begin
            led_d = 4'b1000;
          end
        end
        CMD_BLINK: begin
          mode_d = ST_BLINK;
          led_d  = 4'b1111;
        end
        CMD_PAUSE: begin
          if (w_running) begin
            saved_d = mode_q;
            mode_d  = ST_PAUSED;
          end else if (mode_q == ST_PAUSED) begin
            mode_d = saved_q;
          end
        end
        CMD_SPD_UP: begin
          if (speed_q != 2'd0) begin
            speed_d = speed_q - 2'd1;
          end
        end
        CMD_SPD_DN: begin
          if (speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end else if (w_tick) begin
      case (mode_q)
        ST_FLOW_L: led_d = {led_q[2:0], led_q[3]};
        ST_FLOW_R: led_d = {led_q[0], led_q[3:1]};
        ST_BLINK:  led_d = ~led_q;
        default:   led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q  <= ST_FLOW_L;
      saved_q <= ST_FLOW_L;
      led_q   <= 4'b0001;
      speed_q <= 2'd1;
      pend_q  <= 1'b0;
      cmd_q   <= CMD_STOP;
      base_q  <= 24'd0;
      step_q  <= 2'd0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      led_q   <= led_d;
      speed_q <= speed_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      base_q  <= base_d;
      step_q  <= step_d;
    end
  end

  assign req_a_ready = w_rdy_a;
  assign req_b_ready = w_rdy_b;
  assign led         = led_q;
  assign mode        = mode_q;
  assign speed       = speed_q;
  assign tick        = w_tick;

endmodule
`default_nettype wire
